alu_pipe: RTL and testbench

Parametrised, pipelined integer ALU that supersedes the single-cycle combinational ALU in the execution stage. It computes RV64I/RV32I arithmetic, logic, shift and compare results, including the W-variant word ops. Results then pass through a configurable number of elastic pipeline stages, with valid/ready backpressure and flush. It sits between the issue/register-read stage and write-back, and carries an opaque tag (gl_index/prd/chkp bundle) alongside each result.

---
 rtl/alu_pipe_if.sv | 34 +++
 rtl/alu_pipe.sv | 184 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake/data bundle for the pipelined integer ALU.
// The issue side presents an operation with valid_i/ready_o.
// The write-back side takes results with valid_o/ready_i.
// flush_i and the completion counter travel in the same bundle.
interface alu_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 16
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic             word_i;
  logic [XLEN-1:0]  data_rs1_i;
  logic [XLEN-1:0]  data_rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;
  logic [31:0]      count_o;

  // Driver side: the issue stage plus the write-back consumer.
  modport master (
    output flush_i, valid_i, op_i, word_i, data_rs1_i, data_rs2_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, count_o
  );

  // ALU side.
  modport slave (
    input  flush_i, valid_i, op_i, word_i, data_rs1_i, data_rs2_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, count_o
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined RV32I/RV64I integer ALU.
// The result is computed combinationally at the input and captured into stage 0.
// It then moves through STAGES elastic register stages with valid/ready backpressure.
// flush_i kills every in-flight operation. count_o counts delivered results.
// XLEN must be 32 or 64. STAGES must be in the range 1..4.
module alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  alu_pipe_if.slave  bus
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  full_res;
  logic [XLEN-1:0]  alu_res;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] hand;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [XLEN-1:0]   res_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic [31:0]       count_q;
  logic [31:0]       count_d;
  logic              accept;

  assign rs1 = bus.data_rs1_i;
  assign rs2 = bus.data_rs2_i;

  // Full-width ALU. The shift amount takes the low log2(XLEN) bits of rs2. Reserved opcodes yield 0.
  always_comb begin
    shamt    = rs2[SH_W-1:0];
    full_res = '0;
    case (bus.op_i)
      OP_ADD:  full_res = rs1 + rs2;
      OP_SUB:  full_res = rs1 - rs2;
      OP_SLL:  full_res = rs1 << shamt;
      OP_SLT:  full_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: full_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:  full_res = rs1 ^ rs2;
      OP_SRL:  full_res = rs1 >> shamt;
      OP_SRA:  full_res = $signed(rs1) >>> shamt;
      OP_OR:   full_res = rs1 | rs2;
      OP_AND:  full_res = rs1 & rs2;
      default: full_res = '0;
    endcase
  end

  if (XLEN == 64) begin : g_word
    logic [31:0] w_res;
    logic        w_en;

    // W-variant datapath on the low 32 bits. Only ADD/SUB/SLL/SRL/SRA honour word_i.
    always_comb begin
      w_res = '0;
      w_en  = 1'b0;
      case (bus.op_i)
        OP_ADD: begin
          w_en  = bus.word_i;
          w_res = rs1[31:0] + rs2[31:0];
        end
        OP_SUB: begin
          w_en  = bus.word_i;
          w_res = rs1[31:0] - rs2[31:0];
        end
        OP_SLL: begin
          w_en  = bus.word_i;
          w_res = rs1[31:0] << rs2[4:0];
        end
        OP_SRL: begin
          w_en  = bus.word_i;
          w_res = rs1[31:0] >> rs2[4:0];
        end
        OP_SRA: begin
          w_en  = bus.word_i;
          w_res = $signed(rs1[31:0]) >>> rs2[4:0];
        end
        default: begin
          w_en  = 1'b0;
          w_res = '0;
        end
      endcase
    end

    assign alu_res = w_en ? {{(XLEN-32){w_res[31]}}, w_res} : full_res;
  end else begin : g_no_word
    assign alu_res = full_res;
  end

  // Handshake chain, walked from the output back to stage 0.
  // A stage hands off when it is valid and its successor loads.
  // A stage loads when it is empty or hands off in the same cycle.
  always_comb begin
    hand = '0;
    load = '0;
    hand[STAGES-1] = v_q[STAGES-1] & bus.ready_i;
    load[STAGES-1] = ~v_q[STAGES-1] | hand[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      hand[k] = v_q[k] & load[k+1];
      load[k] = ~v_q[k] | hand[k];
    end
  end

  assign accept = bus.valid_i & load[0] & ~bus.flush_i;

  // Next state for every stage. Data only moves alongside a valid bit.
  // Flush overrides all valid bits.
  always_comb begin
    v_d   = v_q;
    res_d = res_q;
    tag_d = tag_q;

    if (load[0]) begin
      v_d[0] = accept;
      if (accept) begin
        res_d[0] = alu_res;
        tag_d[0] = bus.tag_i;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          res_d[k] = res_q[k-1];
          tag_d[k] = tag_q[k-1];
        end
      end
    end

    if (bus.flush_i) begin
      v_d = '0;
    end
  end

  // Completed-operation counter. It advances on every output handshake, including one during a flush.
  always_comb begin
    count_d = count_q + {31'd0, hand[STAGES-1]};
  end

  // Pipeline and counter state. Asynchronous active-low reset empties the pipe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  assign bus.ready_o  = load[0];
  assign bus.valid_o  = v_q[STAGES-1];
  assign bus.result_o = v_q[STAGES-1] ? res_q[STAGES-1] : '0;
  assign bus.tag_o    = v_q[STAGES-1] ? tag_q[STAGES-1] : '0;
  assign bus.count_o  = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe.
// One instance uses XLEN=64, STAGES=2. A second uses XLEN=32, STAGES=1.
`timescale 1ns/1ps
module tb_alu_pipe;

  localparam int S64 = 2;
  localparam int S32 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt64 = 0;
  int   exp_cnt32 = 0;

  typedef struct {
    logic [3:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  alu_pipe_if #(.XLEN(64), .TAG_W(16)) if64 ();
  alu_pipe_if #(.XLEN(32), .TAG_W(16)) if32 ();

  alu_pipe #(.XLEN(64), .STAGES(S64), .TAG_W(16)) dut64 (
    .clk_i (clk),
    .rstn_i(rst_n),
    .bus   (if64)
  );

  alu_pipe #(.XLEN(32), .STAGES(S32), .TAG_W(16)) dut32 (
    .clk_i (clk),
    .rstn_i(rst_n),
    .bus   (if32)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if64.flush_i = 1'b0; if64.valid_i = 1'b0; if64.op_i = 4'd0; if64.word_i = 1'b0;
    if64.data_rs1_i = '0; if64.data_rs2_i = '0; if64.tag_i = '0; if64.ready_i = 1'b1;
    if32.flush_i = 1'b0; if32.valid_i = 1'b0; if32.op_i = 4'd0; if32.word_i = 1'b0;
    if32.data_rs1_i = '0; if32.data_rs2_i = '0; if32.tag_i = '0; if32.ready_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    n_checks++; if (if64.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst64_ready got %b expected 1", if64.ready_o); end
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst64_valid got %b expected 0", if64.valid_o); end
    n_checks++; if (if64.result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL rst64_result got %h expected 0", if64.result_o); end
    n_checks++; if (if64.tag_o !== 16'd0) begin n_fail++; $display("[TB] FAIL rst64_tag got %h expected 0", if64.tag_o); end
    n_checks++; if (if64.count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst64_count got %0d expected 0", if64.count_o); end
    n_checks++; if (if32.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst32_ready got %b expected 1", if32.ready_o); end
    n_checks++; if (if32.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst32_valid got %b expected 0", if32.valid_o); end
    n_checks++; if (if32.result_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst32_result got %h expected 0", if32.result_o); end
    n_checks++; if (if32.count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL rst32_count got %0d expected 0", if32.count_o); end
    #5 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ops64();
    vec_t t[16];
    t[0]  = '{4'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
    t[1]  = '{4'd7, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF};
    t[2]  = '{4'd6, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'h0000_0000_0000_0001};
    t[3]  = '{4'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    t[4]  = '{4'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    t[5]  = '{4'd1, 1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    t[6]  = '{4'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    t[7]  = '{4'd2, 1'b0, 64'd1, 64'h43, 64'd8};
    t[8]  = '{4'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1};
    t[9]  = '{4'd7, 1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};
    t[10] = '{4'd5, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_0F0F_F0F0_0F0F};
    t[11] = '{4'd12, 1'b0, 64'd5, 64'd3, 64'd0};
    t[12] = '{4'd9, 1'b0, 64'hF0, 64'h3C, 64'h30};
    t[13] = '{4'd8, 1'b0, 64'hF0, 64'h0F, 64'hFF};
    t[14] = '{4'd2, 1'b1, 64'd1, 64'd63, 64'hFFFF_FFFF_8000_0000};
    t[15] = '{4'd3, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0};
    for (int i = 0; i < 16; i++) begin
      if64.valid_i = 1'b1; if64.op_i = t[i].op; if64.word_i = t[i].word;
      if64.data_rs1_i = t[i].a; if64.data_rs2_i = t[i].b; if64.tag_i = 16'h0100 + 16'(i);
      #1;
      n_checks++; if (if64.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ops64_ready[%0d] got %b expected 1", i, if64.ready_o); end
      tick();
      if64.valid_i = 1'b0;
      for (int c = 1; c < S64; c++) begin
        #1;
        n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ops64_early[%0d] got %b expected 0", i, if64.valid_o); end
        tick();
      end
      #1;
      n_checks++; if (if64.valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ops64_valid[%0d] got %b expected 1", i, if64.valid_o); end
      n_checks++; if (if64.result_o !== t[i].exp) begin n_fail++; $display("[TB] FAIL ops64_result[%0d] got %h expected %h", i, if64.result_o, t[i].exp); end
      n_checks++; if (if64.tag_o !== 16'h0100 + 16'(i)) begin n_fail++; $display("[TB] FAIL ops64_tag[%0d] got %h expected %h", i, if64.tag_o, 16'h0100 + 16'(i)); end
      exp_cnt64++;
    end
    tick();
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ops64_drain got %b expected 0", if64.valid_o); end
    n_checks++; if (if64.count_o !== 32'(exp_cnt64)) begin n_fail++; $display("[TB] FAIL ops64_count got %0d expected %0d", if64.count_o, exp_cnt64); end
  endtask

  task automatic test_back_to_back64();
    for (int c = 0; c < 10 + S64; c++) begin
      if (c < 10) begin
        if64.valid_i = 1'b1; if64.op_i = 4'd0; if64.word_i = 1'b0;
        if64.data_rs1_i = 64'(c); if64.data_rs2_i = 64'h100; if64.tag_i = 16'h0200 + 16'(c);
      end else begin
        if64.valid_i = 1'b0;
      end
      #1;
      if (c < 10) begin
        n_checks++; if (if64.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b64_ready[%0d] got %b expected 1", c, if64.ready_o); end
      end
      if (c >= S64) begin
        n_checks++; if (if64.valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b64_valid[%0d] got %b expected 1", c, if64.valid_o); end
        n_checks++; if (if64.tag_o !== 16'h0200 + 16'(c - S64)) begin n_fail++; $display("[TB] FAIL b2b64_tag[%0d] got %h expected %h", c, if64.tag_o, 16'h0200 + 16'(c - S64)); end
        n_checks++; if (if64.result_o !== 64'(c - S64) + 64'h100) begin n_fail++; $display("[TB] FAIL b2b64_result[%0d] got %h expected %h", c, if64.result_o, 64'(c - S64) + 64'h100); end
      end else begin
        n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b64_lat[%0d] got %b expected 0", c, if64.valid_o); end
      end
      tick();
    end
    exp_cnt64 += 10;
    #1;
    n_checks++; if (if64.count_o !== 32'(exp_cnt64)) begin n_fail++; $display("[TB] FAIL b2b64_count got %0d expected %0d", if64.count_o, exp_cnt64); end
  endtask

  task automatic test_backpressure64();
    int sent;
    int rcvd;
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 10; c++) begin
      if64.ready_i = (c >= 6);
      if (sent < 10) begin
        if64.valid_i = 1'b1; if64.op_i = 4'd0; if64.word_i = 1'b0;
        if64.data_rs1_i = 64'(sent * 3); if64.data_rs2_i = 64'h1000; if64.tag_i = 16'h0300 + 16'(sent);
      end else begin
        if64.valid_i = 1'b0;
      end
      #1;
      if (c < 6) begin
        n_checks++; if (if64.ready_o !== (c < S64)) begin n_fail++; $display("[TB] FAIL bp64_ready[%0d] got %b expected %b", c, if64.ready_o, (c < S64)); end
        n_checks++; if (if64.valid_o !== (c >= S64)) begin n_fail++; $display("[TB] FAIL bp64_valid[%0d] got %b expected %b", c, if64.valid_o, (c >= S64)); end
        if (c >= S64) begin
          n_checks++; if (if64.tag_o !== 16'h0300) begin n_fail++; $display("[TB] FAIL bp64_hold_tag[%0d] got %h expected 0300", c, if64.tag_o); end
          n_checks++; if (if64.result_o !== 64'h1000) begin n_fail++; $display("[TB] FAIL bp64_hold_result[%0d] got %h expected 1000", c, if64.result_o); end
        end
      end
      if (if64.valid_o && if64.ready_i) begin
        n_checks++; if (if64.tag_o !== 16'h0300 + 16'(rcvd)) begin n_fail++; $display("[TB] FAIL bp64_order_tag[%0d] got %h expected %h", rcvd, if64.tag_o, 16'h0300 + 16'(rcvd)); end
        n_checks++; if (if64.result_o !== 64'(rcvd * 3) + 64'h1000) begin n_fail++; $display("[TB] FAIL bp64_order_result[%0d] got %h expected %h", rcvd, if64.result_o, 64'(rcvd * 3) + 64'h1000); end
        rcvd++;
      end
      if (if64.valid_i && if64.ready_o) sent++;
      tick();
    end
    if64.valid_i = 1'b0;
    if64.ready_i = 1'b1;
    n_checks++; if (rcvd != 10) begin n_fail++; $display("[TB] FAIL bp64_received got %0d expected 10", rcvd); end
    exp_cnt64 += 10;
    #1;
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp64_dup got %b expected 0", if64.valid_o); end
    n_checks++; if (if64.count_o !== 32'(exp_cnt64)) begin n_fail++; $display("[TB] FAIL bp64_count got %0d expected %0d", if64.count_o, exp_cnt64); end
  endtask

  task automatic test_flush64();
    if64.ready_i = 1'b0; if64.op_i = 4'd0; if64.word_i = 1'b0;
    if64.valid_i = 1'b1; if64.data_rs1_i = 64'd1; if64.data_rs2_i = 64'd1; if64.tag_i = 16'h04A0;
    tick();
    if64.data_rs1_i = 64'd2; if64.tag_i = 16'h04A1;
    tick();
    if64.data_rs1_i = 64'd3; if64.tag_i = 16'h04A2;
    if64.ready_i = 1'b1; if64.flush_i = 1'b1;
    #1;
    n_checks++; if (if64.tag_o !== 16'h04A0) begin n_fail++; $display("[TB] FAIL flush64_head_tag got %h expected 04a0", if64.tag_o); end
    n_checks++; if (if64.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL flush64_ready got %b expected 1", if64.ready_o); end
    tick();
    exp_cnt64++;
    if64.flush_i = 1'b0; if64.valid_i = 1'b0;
    #1;
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush64_valid got %b expected 0", if64.valid_o); end
    n_checks++; if (if64.count_o !== 32'(exp_cnt64)) begin n_fail++; $display("[TB] FAIL flush64_count got %0d expected %0d", if64.count_o, exp_cnt64); end
    if64.valid_i = 1'b1; if64.op_i = 4'd1; if64.data_rs1_i = 64'd10; if64.data_rs2_i = 64'd3; if64.tag_i = 16'h04D0;
    #1;
    n_checks++; if (if64.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL flush64_new_ready got %b expected 1", if64.ready_o); end
    tick();
    if64.valid_i = 1'b0;
    #1;
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush64_new_early got %b expected 0", if64.valid_o); end
    tick();
    n_checks++; if (if64.valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL flush64_new_valid got %b expected 1", if64.valid_o); end
    n_checks++; if (if64.tag_o !== 16'h04D0) begin n_fail++; $display("[TB] FAIL flush64_new_tag got %h expected 04d0", if64.tag_o); end
    n_checks++; if (if64.result_o !== 64'd7) begin n_fail++; $display("[TB] FAIL flush64_new_result got %h expected 7", if64.result_o); end
    exp_cnt64++;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush64_ghost[%0d] got %b expected 0", c, if64.valid_o); end
    end
    n_checks++; if (if64.count_o !== 32'(exp_cnt64)) begin n_fail++; $display("[TB] FAIL flush64_final_count got %0d expected %0d", if64.count_o, exp_cnt64); end
  endtask

  task automatic test_ops32();
    vec_t t[10];
    t[0] = '{4'd0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'h8000_0000};
    t[1] = '{4'd7, 1'b0, 64'h8000_0000, 64'd31, 64'hFFFF_FFFF};
    t[2] = '{4'd2, 1'b0, 64'd1, 64'h21, 64'd2};
    t[3] = '{4'd6, 1'b0, 64'h8000_0000, 64'h3F, 64'd1};
    t[4] = '{4'd3, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'd1};
    t[5] = '{4'd4, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'd0};
    t[6] = '{4'd1, 1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF};
    t[7] = '{4'd7, 1'b1, 64'hF000_0000, 64'd4, 64'hFF00_0000};
    t[8] = '{4'd15, 1'b0, 64'd1, 64'd1, 64'd0};
    t[9] = '{4'd6, 1'b1, 64'hFFFF_FFFF, 64'h24, 64'h0FFF_FFFF};
    for (int i = 0; i < 10; i++) begin
      if32.valid_i = 1'b1; if32.op_i = t[i].op; if32.word_i = t[i].word;
      if32.data_rs1_i = t[i].a[31:0]; if32.data_rs2_i = t[i].b[31:0]; if32.tag_i = 16'h0600 + 16'(i);
      #1;
      n_checks++; if (if32.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ops32_ready[%0d] got %b expected 1", i, if32.ready_o); end
      tick();
      if32.valid_i = 1'b0;
      for (int c = 1; c < S32; c++) begin
        #1;
        n_checks++; if (if32.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ops32_early[%0d] got %b expected 0", i, if32.valid_o); end
        tick();
      end
      #1;
      n_checks++; if (if32.valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ops32_valid[%0d] got %b expected 1", i, if32.valid_o); end
      n_checks++; if (if32.result_o !== t[i].exp[31:0]) begin n_fail++; $display("[TB] FAIL ops32_result[%0d] got %h expected %h", i, if32.result_o, t[i].exp[31:0]); end
      n_checks++; if (if32.tag_o !== 16'h0600 + 16'(i)) begin n_fail++; $display("[TB] FAIL ops32_tag[%0d] got %h expected %h", i, if32.tag_o, 16'h0600 + 16'(i)); end
      exp_cnt32++;
    end
    tick();
    n_checks++; if (if32.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ops32_drain got %b expected 0", if32.valid_o); end
    n_checks++; if (if32.count_o !== 32'(exp_cnt32)) begin n_fail++; $display("[TB] FAIL ops32_count got %0d expected %0d", if32.count_o, exp_cnt32); end
  endtask

  task automatic test_back_to_back32();
    for (int c = 0; c < 5 + S32; c++) begin
      if (c < 5) begin
        if32.valid_i = 1'b1; if32.op_i = 4'd5; if32.word_i = 1'b0;
        if32.data_rs1_i = 32'(c); if32.data_rs2_i = 32'hFF; if32.tag_i = 16'h0700 + 16'(c);
      end else begin
        if32.valid_i = 1'b0;
      end
      #1;
      if (c < 5) begin
        n_checks++; if (if32.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b32_ready[%0d] got %b expected 1", c, if32.ready_o); end
      end
      if (c >= S32) begin
        n_checks++; if (if32.tag_o !== 16'h0700 + 16'(c - S32)) begin n_fail++; $display("[TB] FAIL b2b32_tag[%0d] got %h expected %h", c, if32.tag_o, 16'h0700 + 16'(c - S32)); end
        n_checks++; if (if32.result_o !== (32'(c - S32) ^ 32'hFF)) begin n_fail++; $display("[TB] FAIL b2b32_result[%0d] got %h expected %h", c, if32.result_o, 32'(c - S32) ^ 32'hFF); end
      end
      tick();
    end
    exp_cnt32 += 5;
    #1;
    n_checks++; if (if32.count_o !== 32'(exp_cnt32)) begin n_fail++; $display("[TB] FAIL b2b32_count got %0d expected %0d", if32.count_o, exp_cnt32); end
  endtask

  task automatic test_backpressure32();
    int sent;
    int rcvd;
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 30 && rcvd < 5; c++) begin
      if32.ready_i = (c >= 4);
      if (sent < 5) begin
        if32.valid_i = 1'b1; if32.op_i = 4'd8; if32.word_i = 1'b0;
        if32.data_rs1_i = 32'(sent); if32.data_rs2_i = 32'h100; if32.tag_i = 16'h0800 + 16'(sent);
      end else begin
        if32.valid_i = 1'b0;
      end
      #1;
      if (c < 4) begin
        n_checks++; if (if32.ready_o !== (c < S32)) begin n_fail++; $display("[TB] FAIL bp32_ready[%0d] got %b expected %b", c, if32.ready_o, (c < S32)); end
        if (c >= S32) begin
          n_checks++; if (if32.tag_o !== 16'h0800) begin n_fail++; $display("[TB] FAIL bp32_hold_tag[%0d] got %h expected 0800", c, if32.tag_o); end
        end
      end
      if (if32.valid_o && if32.ready_i) begin
        n_checks++; if (if32.tag_o !== 16'h0800 + 16'(rcvd)) begin n_fail++; $display("[TB] FAIL bp32_order_tag[%0d] got %h expected %h", rcvd, if32.tag_o, 16'h0800 + 16'(rcvd)); end
        n_checks++; if (if32.result_o !== (32'(rcvd) | 32'h100)) begin n_fail++; $display("[TB] FAIL bp32_order_result[%0d] got %h expected %h", rcvd, if32.result_o, 32'(rcvd) | 32'h100); end
        rcvd++;
      end
      if (if32.valid_i && if32.ready_o) sent++;
      tick();
    end
    if32.valid_i = 1'b0;
    if32.ready_i = 1'b1;
    n_checks++; if (rcvd != 5) begin n_fail++; $display("[TB] FAIL bp32_received got %0d expected 5", rcvd); end
    exp_cnt32 += 5;
    #1;
    n_checks++; if (if32.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bp32_dup got %b expected 0", if32.valid_o); end
    n_checks++; if (if32.count_o !== 32'(exp_cnt32)) begin n_fail++; $display("[TB] FAIL bp32_count got %0d expected %0d", if32.count_o, exp_cnt32); end
  endtask

  task automatic test_reset_midstream();
    if64.ready_i = 1'b0; if32.ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if64.valid_i = 1'b1; if64.op_i = 4'd0; if64.word_i = 1'b0;
      if64.data_rs1_i = 64'(c); if64.data_rs2_i = 64'd1; if64.tag_i = 16'h0900 + 16'(c);
      if32.valid_i = 1'b1; if32.op_i = 4'd0; if32.word_i = 1'b0;
      if32.data_rs1_i = 32'(c); if32.data_rs2_i = 32'd1; if32.tag_i = 16'h0900 + 16'(c);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid64_valid got %b expected 0", if64.valid_o); end
    n_checks++; if (if64.count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL mid64_count got %0d expected 0", if64.count_o); end
    n_checks++; if (if64.ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid64_ready got %b expected 1", if64.ready_o); end
    n_checks++; if (if64.result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL mid64_result got %h expected 0", if64.result_o); end
    n_checks++; if (if32.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid32_valid got %b expected 0", if32.valid_o); end
    n_checks++; if (if32.count_o !== 32'd0) begin n_fail++; $display("[TB] FAIL mid32_count got %0d expected 0", if32.count_o); end
    tick();
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid64_held got %b expected 0", if64.valid_o); end
    idle_inputs();
    #2 rst_n = 1'b1;
    tick();
    exp_cnt64 = 0;
    exp_cnt32 = 0;
    if64.valid_i = 1'b1; if64.op_i = 4'd0; if64.data_rs1_i = 64'd2; if64.data_rs2_i = 64'd3; if64.tag_i = 16'h05A0;
    if32.valid_i = 1'b1; if32.op_i = 4'd0; if32.data_rs1_i = 32'd2; if32.data_rs2_i = 32'd3; if32.tag_i = 16'h05A0;
    tick();
    if64.valid_i = 1'b0; if32.valid_i = 1'b0;
    #1;
    n_checks++; if (if32.result_o !== 32'd5) begin n_fail++; $display("[TB] FAIL post32_result got %h expected 5", if32.result_o); end
    n_checks++; if (if64.valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL post64_early got %b expected 0", if64.valid_o); end
    tick();
    exp_cnt32++;
    n_checks++; if (if64.result_o !== 64'd5) begin n_fail++; $display("[TB] FAIL post64_result got %h expected 5", if64.result_o); end
    n_checks++; if (if32.count_o !== 32'(exp_cnt32)) begin n_fail++; $display("[TB] FAIL post32_count got %0d expected %0d", if32.count_o, exp_cnt32); end
    tick();
    exp_cnt64++;
    n_checks++; if (if64.count_o !== 32'(exp_cnt64)) begin n_fail++; $display("[TB] FAIL post64_count got %0d expected %0d", if64.count_o, exp_cnt64); end
  endtask

  // Bounded run time so a stuck handshake cannot hang the simulation.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] alu_pipe directed bench starting");
    test_reset();
    test_ops64();
    test_back_to_back64();
    test_backpressure64();
    test_flush64();
    test_ops32();
    test_back_to_back32();
    test_backpressure32();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
